// File: rtl/dmem_store_buffer_if.sv
// dmem_store_buffer_if
//   Groups the datapath-side load/store signals, the flush handshake, the
//   dmem port and the status flags of the store buffer.
//   slave  : the store buffer itself
//   master : whatever drives it (datapath + dmem, or a testbench)
//   Signals:
//     cpu_we/cpu_re/cpu_addr/cpu_wdata -> buffer   load/store request
//     cpu_rdata/cpu_stall              <- buffer   load data, hold request
//     flush -> buffer, flush_done <- buffer        full-drain handshake
//     mem_we/mem_addr/mem_wdata <- buffer, mem_rdata -> buffer   dmem port
//     empty/full                       <- buffer   registered occupancy flags
interface dmem_store_buffer_if;
    logic        cpu_we;
    logic        cpu_re;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        flush;
    logic        flush_done;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        empty;
    logic        full;

    modport slave (
        input  cpu_we, cpu_re, cpu_addr, cpu_wdata, flush, mem_rdata,
        output cpu_rdata, cpu_stall, flush_done, mem_we, mem_addr, mem_wdata,
               empty, full
    );

    modport master (
        output cpu_we, cpu_re, cpu_addr, cpu_wdata, flush, mem_rdata,
        input  cpu_rdata, cpu_stall, flush_done, mem_we, mem_addr, mem_wdata,
               empty, full
    );
endinterface

// File: rtl/dmem_store_buffer.sv
// dmem_store_buffer
//   Posted-write buffer between the datapath load/store path and a dmem with
//   one shared address port (async read, sync write). Stores are queued in a
//   circular FIFO and drained one per cycle whenever no load owns the port.
//   Loads forward from the youngest matching queued word, else use dmem data.
//   A flush request enters DRAIN, stalls all accesses until the queue is
//   empty, then returns to RUN with a one-cycle flush_done pulse.
//   Ports:
//     clk      rising-edge clock
//     reset_n  asynchronous active-low reset
//     bus      dmem_store_buffer_if.slave (cpu, flush, dmem and flag signals)
module dmem_store_buffer #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    dmem_store_buffer_if.slave   bus
);

    typedef enum logic {RUN, DRAIN} state_t;

    state_t               state_q, state_d;
    logic [PTR_W-1:0]     head_q, head_d;
    logic [PTR_W-1:0]     tail_q, tail_d;
    logic [PTR_W:0]       count_q, count_d;
    logic                 flush_done_q, flush_done_d;

    logic [29:0]          addr_q [DEPTH];
    logic [31:0]          data_q [DEPTH];

    logic                 load_port;
    logic                 drain;
    logic                 enq;
    logic                 stall;
    logic                 full;
    logic                 fwd_hit;
    logic [31:0]          fwd_data;
    logic [PTR_W-1:0]     idx;

    // Control: port arbitration, stall, enqueue, pointer/count and FSM.
    always_comb begin
        load_port    = bus.cpu_re && (state_q == RUN);
        drain        = (count_q != '0) && !load_port;
        full         = (count_q == (PTR_W+1)'(DEPTH));
        // A simultaneous load+store is taken as a load: no enqueue, no stall.
        if (state_q == RUN) begin
            stall = bus.cpu_we && !bus.cpu_re && full;
        end else begin
            stall = bus.cpu_we || bus.cpu_re;
        end
        enq          = (state_q == RUN) && bus.cpu_we && !bus.cpu_re && !stall;
        head_d       = head_q + PTR_W'(drain);
        tail_d       = tail_q + PTR_W'(enq);
        count_d      = count_q + (PTR_W+1)'(enq) - (PTR_W+1)'(drain);
        state_d      = state_q;
        flush_done_d = 1'b0;
        case (state_q)
            RUN: begin
                if (bus.flush) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (count_d == '0) begin
                    state_d      = RUN;
                    flush_done_d = 1'b1;
                end
            end
            default: state_d = RUN;
        endcase
    end

    // Forwarding: scan oldest to youngest so the youngest match wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        idx      = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = head_q + PTR_W'(i);
            if ((i < 32'(count_q)) && (addr_q[idx] == bus.cpu_addr[31:2])) begin
                fwd_hit  = 1'b1;
                fwd_data = data_q[idx];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= RUN;
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            flush_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            flush_done_q <= flush_done_d;
        end
    end

    // Entry storage needs no reset: validity is defined by head/count.
    always_ff @(posedge clk) begin
        if (enq) begin
            addr_q[tail_q] <= bus.cpu_addr[31:2];
            data_q[tail_q] <= bus.cpu_wdata;
        end
    end

    assign bus.mem_we     = drain;
    assign bus.mem_addr   = drain ? {addr_q[head_q], 2'b00} : bus.cpu_addr;
    assign bus.mem_wdata  = data_q[head_q];
    assign bus.cpu_rdata  = fwd_hit ? fwd_data : bus.mem_rdata;
    assign bus.cpu_stall  = stall;
    assign bus.flush_done = flush_done_q;
    assign bus.empty      = (count_q == '0);
    assign bus.full       = full;

endmodule
